// File: rtl/proc_scheduler.sv
// Round-robin process scheduler: slot table (valid + saved PC), quantum timer and PC-module swap handshake.
// Define SCHED_PREEMPT_STATS_EN to add the saturating preempt_count output (timer-triggered switches).
module proc_scheduler #(
  parameter int NUM_PROCS       = 4,
  parameter int PC_WIDTH        = 10,
  parameter int QUANTUM_WIDTH   = 16,
  parameter int DEFAULT_QUANTUM = 1000,
  localparam int IDW            = $clog2(NUM_PROCS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     quantum_load,
  input  logic [QUANTUM_WIDTH-1:0] quantum_value,
  input  logic                     yield,
  input  logic                     halt_proc,
  input  logic [PC_WIDTH-1:0]      cur_pc,
  input  logic                     proc_create,
  input  logic [PC_WIDTH-1:0]      create_pc,
  output logic                     create_ack,
  output logic [IDW-1:0]           create_slot,
  output logic                     create_full,
  input  logic                     proc_kill,
  input  logic [IDW-1:0]           kill_id,
  output logic                     swap_req,
  output logic [PC_WIDTH-1:0]      swap_pc,
  input  logic                     swap_ack,
  output logic [IDW-1:0]           exec_proc,
  output logic [NUM_PROCS-1:0]     valid_mask,
  output logic                     user_idle
`ifdef SCHED_PREEMPT_STATS_EN
  , output logic [15:0]            preempt_count
`endif
);

  typedef enum logic [1:0] {RUN, SAVE, SELECT, DISPATCH} state_t;

  state_t                   state_q, state_d;
  logic [NUM_PROCS-1:0]     valid_q, valid_d;
  logic [PC_WIDTH-1:0]      saved_pc_q [NUM_PROCS];
  logic [PC_WIDTH-1:0]      saved_pc_d [NUM_PROCS];
  logic [IDW-1:0]           exec_q, exec_d, next_q, next_d;
  logic [QUANTUM_WIDTH-1:0] quantum_q, quantum_d, counter_q, counter_d;
  logic                     drop_q, drop_d;
  logic                     create_ack_q, create_ack_d, create_full_q, create_full_d;
  logic [IDW-1:0]           create_slot_q, create_slot_d;
  logic                     user_idle_q;

  logic           kill_hit, self_kill, kill_next, decrementing, timer_fire, trigger, next_ok;
  logic           free_found;
  logic [IDW-1:0] free_slot, scan_slot;
  int             cand;

  assign kill_hit     = proc_kill && (kill_id != '0) && (32'(kill_id) < NUM_PROCS) && valid_q[kill_id];
  assign self_kill    = kill_hit && (kill_id == exec_q);
  assign kill_next    = kill_hit && (kill_id == next_q);
  assign decrementing = (state_q == RUN) && enable && (exec_q != '0);
  assign timer_fire   = decrementing && (counter_q == QUANTUM_WIDTH'(1));
  assign trigger      = timer_fire || yield || halt_proc || self_kill;
  assign next_ok      = (next_q == '0) || valid_q[next_q];

  // Round-robin scan: descending loop so the nearest slot after exec_q wins; i==NUM_PROCS reselects exec_q.
  always_comb begin
    scan_slot  = '0;
    free_found = 1'b0;
    free_slot  = '0;
    cand       = 0;
    for (int i = NUM_PROCS; i >= 1; i--) begin
      cand = (int'(exec_q) + i) % NUM_PROCS;
      if (cand != 0 && valid_q[IDW'(cand)]) scan_slot = IDW'(cand);
    end
    for (int i = NUM_PROCS - 1; i >= 1; i--) begin
      if (!valid_q[IDW'(i)]) begin
        free_found = 1'b1;
        free_slot  = IDW'(i);
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    valid_d       = valid_q;
    saved_pc_d    = saved_pc_q;
    exec_d        = exec_q;
    next_d        = next_q;
    quantum_d     = quantum_q;
    counter_d     = counter_q;
    drop_d        = drop_q;
    create_ack_d  = 1'b0;
    create_full_d = 1'b0;
    create_slot_d = create_slot_q;

    unique case (state_q)
      RUN: begin
        if (decrementing) counter_d = counter_q - QUANTUM_WIDTH'(1);
        if (trigger) begin
          state_d = SAVE;
          drop_d  = (halt_proc && exec_q != '0) || self_kill;
        end
      end
      SAVE: begin
        if (drop_q) valid_d[exec_q] = 1'b0;
        else        saved_pc_d[exec_q] = cur_pc;
        state_d = SELECT;
      end
      SELECT: begin
        next_d  = scan_slot;
        state_d = DISPATCH;
      end
      DISPATCH: begin
        if (kill_next || !next_ok) begin
          state_d = SELECT;
        end else if (swap_ack) begin
          exec_d    = next_q;
          counter_d = quantum_q;
          state_d   = RUN;
        end
      end
      default: state_d = RUN;
    endcase

    if (kill_hit) valid_d[kill_id] = 1'b0;

    // Allocation looks at valid_q, so a slot killed this cycle is never handed out in the same cycle.
    if (proc_create) begin
      if (free_found) begin
        valid_d[free_slot]    = 1'b1;
        saved_pc_d[free_slot] = create_pc;
        create_ack_d          = 1'b1;
        create_slot_d         = free_slot;
      end else begin
        create_full_d = 1'b1;
      end
    end

    if (quantum_load)
      quantum_d = (quantum_value == '0) ? QUANTUM_WIDTH'(1) : quantum_value;

    valid_d[0] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= RUN;
      valid_q       <= NUM_PROCS'(1);
      exec_q        <= '0;
      next_q        <= '0;
      quantum_q     <= QUANTUM_WIDTH'(DEFAULT_QUANTUM);
      counter_q     <= QUANTUM_WIDTH'(DEFAULT_QUANTUM);
      drop_q        <= 1'b0;
      create_ack_q  <= 1'b0;
      create_full_q <= 1'b0;
      create_slot_q <= '0;
      user_idle_q   <= 1'b1;
    end else begin
      state_q       <= state_d;
      valid_q       <= valid_d;
      exec_q        <= exec_d;
      next_q        <= next_d;
      quantum_q     <= quantum_d;
      counter_q     <= counter_d;
      drop_q        <= drop_d;
      create_ack_q  <= create_ack_d;
      create_full_q <= create_full_d;
      create_slot_q <= create_slot_d;
      user_idle_q   <= ~|valid_d[NUM_PROCS-1:1];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PROCS; gi++) begin : g_pc
      always_ff @(posedge clk) begin
        if (!reset) saved_pc_q[gi] <= '0;
        else        saved_pc_q[gi] <= saved_pc_d[gi];
      end
    end
  endgenerate

`ifdef SCHED_PREEMPT_STATS_EN
  logic [15:0] preempt_q;
  always_ff @(posedge clk) begin
    if (!reset)                                preempt_q <= '0;
    else if (timer_fire && preempt_q != 16'hFFFF) preempt_q <= preempt_q + 16'd1;
  end
  assign preempt_count = preempt_q;
`endif

  assign swap_req    = (state_q == DISPATCH) && next_ok;
  assign swap_pc     = saved_pc_q[next_q];
  assign exec_proc   = exec_q;
  assign valid_mask  = valid_q;
  assign user_idle   = user_idle_q;
  assign create_ack  = create_ack_q;
  assign create_full = create_full_q;
  assign create_slot = create_slot_q;

endmodule

// File: tb/tb_proc_scheduler.sv
// Randomized bench for proc_scheduler against a transaction-level slot-table model.
module tb_proc_scheduler;
  localparam int NP  = 4;
  localparam int PCW = 10;
  localparam int QW  = 16;

  logic           clk = 1'b0;
  logic           reset = 1'b0, enable = 1'b0, quantum_load = 1'b0;
  logic [QW-1:0]  quantum_value = '0;
  logic           yield = 1'b0, halt_proc = 1'b0, proc_create = 1'b0, proc_kill = 1'b0, swap_ack = 1'b0;
  logic [PCW-1:0] cur_pc = '0, create_pc = '0;
  logic [1:0]     kill_id = '0;
  logic           create_ack, create_full, swap_req, user_idle;
  logic [1:0]     create_slot, exec_proc;
  logic [PCW-1:0] swap_pc;
  logic [NP-1:0]  valid_mask;
`ifdef SCHED_PREEMPT_STATS_EN
  logic [15:0]    preempt_count;
`endif

  always #5 clk = ~clk;

  proc_scheduler dut (
    .clk(clk), .reset(reset), .enable(enable), .quantum_load(quantum_load),
    .quantum_value(quantum_value), .yield(yield), .halt_proc(halt_proc), .cur_pc(cur_pc),
    .proc_create(proc_create), .create_pc(create_pc), .create_ack(create_ack),
    .create_slot(create_slot), .create_full(create_full), .proc_kill(proc_kill),
    .kill_id(kill_id), .swap_req(swap_req), .swap_pc(swap_pc), .swap_ack(swap_ack),
    .exec_proc(exec_proc), .valid_mask(valid_mask), .user_idle(user_idle)
`ifdef SCHED_PREEMPT_STATS_EN
    , .preempt_count(preempt_count)
`endif
  );

  int vectors = 0, miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model: the slot table as plain arrays, plus who runs and the quantum it was given.
  bit             m_valid [NP];
  logic [PCW-1:0] m_pc    [NP];
  int             m_exec, m_quantum, m_reload, m_preempt;

  function automatic int m_next();
    for (int i = 1; i <= NP; i++) begin
      int c = (m_exec + i) % NP;
      if (c != 0 && m_valid[c]) return c;
    end
    return 0;
  endfunction

  function automatic int m_free();
    for (int i = 1; i < NP; i++) if (!m_valid[i]) return i;
    return -1;
  endfunction

  function automatic logic [31:0] m_mask();
    logic [31:0] m = '0;
    for (int i = 0; i < NP; i++) m[i] = m_valid[i];
    return m;
  endfunction

  function automatic logic [31:0] m_idle();
    for (int i = 1; i < NP; i++) if (m_valid[i]) return 32'd0;
    return 32'd1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NP; i++) begin m_valid[i] = (i == 0); m_pc[i] = '0; end
    m_exec = 0; m_quantum = 1000; m_reload = 1000; m_preempt = 0;
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_mask"}, valid_mask, m_mask());
    chk({tag, "_exec"}, exec_proc, m_exec);
    chk({tag, "_idle"}, user_idle, m_idle());
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step(); step();
    reset = 1'b1;
    model_reset();
    chk("rst_swap_req", swap_req, 0);
    chk("rst_create_ack", create_ack, 0);
    chk("rst_create_full", create_full, 0);
    chk("rst_create_slot", create_slot, 0);
    check_state("rst");
  endtask

  task automatic do_qload(input int v);
    quantum_load = 1'b1; quantum_value = QW'(v);
    step();
    quantum_load = 1'b0;
    m_quantum = (v == 0) ? 1 : v;
  endtask

  // Create (optionally with a same-cycle kill); caller keeps kill off the running user slot.
  task automatic do_create(input logic [PCW-1:0] pc, input int kill_same);
    int f;
    proc_create = 1'b1; create_pc = pc;
    if (kill_same >= 0) begin proc_kill = 1'b1; kill_id = 2'(kill_same); end
    step();
    proc_create = 1'b0; proc_kill = 1'b0;
    f = m_free();
    if (kill_same > 0 && m_valid[kill_same]) m_valid[kill_same] = 1'b0;
    if (f > 0) begin
      chk("create_ack", create_ack, 1);
      chk("create_slot", create_slot, f);
      chk("create_full_n", create_full, 0);
      m_valid[f] = 1'b1; m_pc[f] = pc;
    end else begin
      chk("create_ack_n", create_ack, 0);
      chk("create_full", create_full, 1);
    end
    check_state("create");
    step();
    chk("create_pulse", {30'd0, create_ack, create_full}, 0);
  endtask

  task automatic do_kill(input int id);
    proc_kill = 1'b1; kill_id = 2'(id);
    step();
    proc_kill = 1'b0;
    if (id != 0 && m_valid[id]) m_valid[id] = 1'b0;
    check_state("kill");
  endtask

  // Entered on the first cycle swap_req must be visible; delay<0 picks a random ack delay.
  task automatic dispatch_phase(input int delay, input bit abort);
    int nx = m_next();
    int d  = (delay < 0) ? int'($urandom % 4) : delay;
    chk("swap_req_on", swap_req, 1);
    chk("swap_pc", swap_pc, m_pc[nx]);
    if (abort) begin
      reset = 1'b0;
      step();
      reset = 1'b1;
      model_reset();
      chk("abort_swap_req", swap_req, 0);
      check_state("abort");
      return;
    end
    if (nx != 0 && ($urandom % 4) == 0) begin
      proc_kill = 1'b1; kill_id = 2'(nx);
      step();
      proc_kill = 1'b0;
      m_valid[nx] = 1'b0;
      chk("killnext_drop", swap_req, 0);
      step();
      nx = m_next();
      chk("killnext_req", swap_req, 1);
      chk("killnext_pc", swap_pc, m_pc[nx]);
    end
    for (int i = 0; i < d; i++) begin
      step();
      chk("hold_req", swap_req, 1);
      chk("hold_pc", swap_pc, m_pc[nx]);
    end
    swap_ack = 1'b1;
    step();
    swap_ack = 1'b0;
    m_exec = nx; m_reload = m_quantum;
    chk("ack_req_off", swap_req, 0);
    check_state("ack");
  endtask

  // kind: 0 yield, 1 halt, 2 self-kill. cur_pc differs in the trigger and post-SAVE cycles.
  task automatic do_trigger(input int kind, input int delay, input bit abort);
    logic [PCW-1:0] pc = PCW'($urandom);
    bit drop;
    cur_pc = ~pc;
    case (kind)
      0: yield = 1'b1;
      1: halt_proc = 1'b1;
      default: begin proc_kill = 1'b1; kill_id = 2'(m_exec); end
    endcase
    step();
    yield = 1'b0; halt_proc = 1'b0; proc_kill = 1'b0;
    cur_pc = pc;
    drop = (kind == 1 && m_exec != 0) || (kind == 2);
    if (drop) m_valid[m_exec] = 1'b0;
    else      m_pc[m_exec] = pc;
    chk("lat_t1", swap_req, 0);
    step();
    cur_pc = PCW'($urandom);
    chk("lat_t2", swap_req, 0);
    step();
    dispatch_phase(delay, abort);
  endtask

  // Timer expiry with enable randomly dropped; counter starts at the quantum loaded at the last ack.
  task automatic do_timer();
    int remaining = m_reload;
    int trig = -1;
    logic [PCW-1:0] pc_s = PCW'($urandom);
    for (int k = 1; !(trig >= 0 && k == trig + 3); k++) begin
      bit en = (k > 30) ? 1'b1 : (($urandom % 4) != 0);
      chk("tmr_quiet", swap_req, 0);
      enable = en;
      if (remaining > 0 && en) begin
        remaining--;
        if (remaining == 0) trig = k;
      end
      cur_pc = (trig >= 0 && k == trig + 1) ? pc_s : PCW'($urandom);
      step();
    end
    enable = 1'b0;
    m_preempt++;
    m_pc[m_exec] = pc_s;
    dispatch_phase(-1, 1'b0);
  endtask

  initial begin
    model_reset();
    do_reset();
    do_qload(5);
    do_create(10'h040, -1);
    do_create(10'h123, -1);
    do_trigger(0, -1, 1'b0);            // kernel yield -> slot 1
    do_timer();                         // slot 1 preempted -> slot 2
    do_trigger(0, 0, 1'b0);             // -> slot 1, its saved PC returned
    do_create(10'h2AA, -1);
    do_create(10'h155, -1);             // all user slots taken
    do_trigger(0, -1, 1'b0);
    do_trigger(0, -1, 1'b0);
    if (m_exec == 3) do_trigger(1, -1, 1'b0);   // halt in slot 3 wraps to slot 1
    for (int i = 1; i < NP; i++) if (i != m_exec && m_valid[i]) do_kill(i);
    do_kill(0);
    do_trigger(1, 10, 1'b0);            // last user slot halts -> kernel, ack withheld
    do_create(10'h011, -1);
    do_create(10'h022, -1);
    do_create(10'h033, -1);
    do_create(10'h044, 2);              // same-cycle kill does not free a slot for the create
    do_create(10'h055, -1);
    do_trigger(0, -1, 1'b1);            // reset in DISPATCH
    do_qload(0);
    do_create(10'h066, -1);
    do_trigger(0, -1, 1'b0);
    do_timer();                         // quantum 0 behaves as 1
    for (int n = 0; n < 150; n++) begin
      int r = $urandom % 8;
      int id = $urandom % NP;
      case (r)
        0, 1: do_create(PCW'($urandom), (($urandom % 3) == 0 && !(id == m_exec && id != 0)) ? id : -1);
        2: if (!(id == m_exec && id != 0)) do_kill(id);
        3: do_qload($urandom % 7);
        4, 5: do_trigger((m_exec != 0) ? int'($urandom % 3) : int'($urandom % 2), -1, 1'b0);
        default: if (m_exec != 0) do_timer(); else do_trigger(0, -1, 1'b0);
      endcase
    end
`ifdef SCHED_PREEMPT_STATS_EN
    chk("preempt_count", preempt_count, m_preempt);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
